int_dispatch_ctrl: RTL and testbench
====================================

# int_dispatch_ctrl

Sequencing controller for `interrupt_manager`. It decides when a pending interrupt is taken and when an attended one is retired, and it drives the one-hot `s_calli` / `s_reti` pulses that update the manager's Request/Attention registers. It also handshakes the PC save/restore with the return-address stack and stalls the CPU control unit while doing so. It sits between `interrupt_manager`, the return stack and the control unit of the single-cycle CPU.

## Interface
- `WIDTH`, default 8: number of interrupt lines. Bit 0 is the highest priority.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `int_s`  in  WIDTH: pending requests, from `interrupt_manager`.
- `int_a`  in  WIDTH: interrupts currently attended, from `interrupt_manager`.
- `instr_boundary`  in  1: the CPU can be redirected this cycle.
- `reti_inst`  in  1: the control unit has decoded a reti.
- `mask_we`  in  1: write enable for the mask register.
- `mask_d`  in  WIDTH: mask write data; 1 enables the line.
- `gie_set`, `gie_clr`  in  1 each: set or clear the global enable.
- `push_ack`, `pop_ack`  in  1 each: the return stack completed a push or a pop.
- `s_calli`  out  WIDTH: one-hot pulse marking an interrupt as attended.
- `s_reti`  out  WIDTH: one-hot pulse retiring an interrupt.
- `irq_take`  out  1: PC mux selects the manager's `addr`.
- `pc_push`, `pc_pop`  out  1 each: return stack requests.
- `stall`  out  1: holds the CPU.
- `mask`  out  WIDTH, `gie`  out  1: current configuration.
- `depth`  out  $clog2(WIDTH+1): current nesting level.
- `spurious_reti`  out  1: sticky error flag.

## Operation
- `la` is the lowest set bit of `int_a`, as a one-hot value.
- `prio_ok` is all-ones when `int_a` is 0, otherwise `la - 1` (unsigned, WIDTH bits), meaning only strictly higher-priority lines qualify.
- `elig` = `int_s & mask & ~int_a & prio_ok`.
- `sel` is the lowest set bit of `elig`; it is registered on leaving IDLE.
- States:
  - IDLE:
    - If `reti_inst` and `depth` > 0, go to POP; this has priority over taking an interrupt.
    - Else if `reti_inst` and `depth` == 0, set `spurious_reti` and stay in IDLE.
    - Else if `gie`, `instr_boundary` and `elig` != 0, latch `sel` and go to PUSH.
  - PUSH: `pc_push` = 1 until `push_ack` is sampled high, then go to VECTOR.
  - VECTOR: one cycle with `s_calli` = `sel_q`, `irq_take` = 1 and `depth` + 1; then go to IDLE.
  - POP: `pc_pop` = 1 until `pop_ack` is sampled high, then go to RETI. In RETI the retired line is `la`, latched on entry to POP.
  - RETI: one cycle with `s_reti` = `la_q` and `depth` − 1; then go to IDLE.
- `stall` = 1 in PUSH, VECTOR, POP and RETI.
- `s_calli` and `s_reti` are zero in every other state. They are never nonzero in the same cycle.
- Mask and global enable:
  - `mask_we` loads `mask` at the next edge in any state.
  - If `gie_set` and `gie_clr` are both high, clear wins.
  - Configuration changes never abort an in-flight PUSH or POP.
- If a request drops while in PUSH, the controller still completes VECTOR with the latched `sel_q`.
- Strict preemption bounds `depth` at WIDTH. A `depth` increment past WIDTH is a design error and is asserted against.

## Timing
- Reset (any state, mid-handshake included): state is IDLE, and all outputs are 0, including `mask` = 0, `gie` = 0, `depth` = 0 and `spurious_reti` = 0. `pc_push` and `pc_pop` drop asynchronously.
- Minimum take latency, with the eligible request and boundary sampled at edge 0:
  - PUSH during cycle 1; `push_ack` is accepted in the same cycle as `pc_push`.
  - VECTOR during cycle 2.
  - IDLE in cycle 3, with `int_a` already updated by the manager. No double take is possible.
- Each extra cycle without ack adds one cycle of latency.
- Minimum reti latency: POP in cycle 1, RETI in cycle 2, IDLE in cycle 3.
- All outputs are registered-state decodes. There are no combinational paths from `push_ack` or `pop_ack` to `s_calli` or `s_reti`.

## Structure
- Package `int_ctrl_pkg`:
  - state encoding localparams: IDLE, PUSH, VECTOR, POP, RETI;
  - default `WIDTH` = 8;
  - depth width function.
- Reuse the existing `max_priority_bit` twice, for `sel` from `elig` and for `la` from `int_a`. No new sub-module.

## Test plan
- mask = 8'hFF, gie = 1, `int_s` = 8'b0000_0100, boundary high, ack immediate: `pc_push` in cycle 1; `s_calli` = 8'h04 with `irq_take` in cycle 2; `depth` = 1 afterwards.
- Nesting: with `int_a` = 8'h04, request 8'h02 is taken (`s_calli` = 8'h02, `depth` = 2), while request 8'h08 is ignored until both have retired.
- reti with `int_a` = 8'h06: `s_reti` = 8'h02 first, then 8'h04 on the next reti; `depth` goes 2→1→0. A reti at `depth` = 0 sets `spurious_reti` and produces no `s_reti`.
- `push_ack` delayed 3 cycles while `int_s` drops: `stall` is held for 5 cycles and `s_calli` still equals the latched value.
- `reti_inst` and an eligible request in the same IDLE cycle: POP is entered first, and the request is taken after RETI.
- Reset asserted during PUSH: `pc_push`, `stall` and `depth` go to 0 immediately; `mask` = 0 and `gie` = 0. No `s_calli` follows.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared constants for the interrupt dispatch controller:
//               state encoding, default line count, and the helper that
//               sizes the nesting-depth counter.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    // Default number of interrupt lines; bit 0 is the highest priority.
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer state encoding.
    localparam int         STATE_W = 3;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PUSH    = 3'd1;
    localparam logic [2:0] VECTOR  = 3'd2;
    localparam logic [2:0] POP     = 3'd3;
    localparam logic [2:0] RETI    = 3'd4;

    // Strict preemption allows at most one attended interrupt per line, so
    // the depth counter must hold the values 0..width inclusive.
    function automatic int depth_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_priority_bit.sv
`default_nettype none
// ============================================================================
// Module      : max_priority_bit
// Description : Isolates the highest-priority (lowest-index) set bit of a
//               request vector as a one-hot value; zero in, zero out.
// Ports       : req   in  WIDTH  request vector
//               grant out WIDTH  one-hot lowest set bit of req
// Revision    : 1.0 - initial release
// ============================================================================
module max_priority_bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    // Two's complement trick: req & -req keeps only the lowest set bit.
    assign grant = req & (~req + C_ONE);

endmodule
`default_nettype wire

// File: rtl/int_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_dispatch_ctrl
// Description : Sequencing controller for interrupt_manager. Decides when a
//               pending interrupt is taken and when an attended one is
//               retired, drives the one-hot s_calli / s_reti update pulses,
//               handshakes PC save/restore with the return stack and stalls
//               the CPU while doing so.
// Ports       : clk, reset (async, active-high)
//               int_s / int_a     pending / attended lines from the manager
//               instr_boundary    CPU may be redirected this cycle
//               reti_inst         control unit decoded a reti
//               mask_we, mask_d   mask register write (1 enables a line)
//               gie_set, gie_clr  global enable control (clear wins)
//               push_ack, pop_ack return stack handshake completion
//               s_calli, s_reti   one-hot attend / retire pulses
//               irq_take          PC mux selects the manager's vector
//               pc_push, pc_pop   return stack requests
//               stall             holds the CPU
//               mask, gie, depth, spurious_reti  status
// Revision    : 1.0 - initial release
// ============================================================================
module int_dispatch_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              int_s,
    input  logic [WIDTH-1:0]              int_a,
    input  logic                          instr_boundary,
    input  logic                          reti_inst,
    input  logic                          mask_we,
    input  logic [WIDTH-1:0]              mask_d,
    input  logic                          gie_set,
    input  logic                          gie_clr,
    input  logic                          push_ack,
    input  logic                          pop_ack,
    output logic [WIDTH-1:0]              s_calli,
    output logic [WIDTH-1:0]              s_reti,
    output logic                          irq_take,
    output logic                          pc_push,
    output logic                          pc_pop,
    output logic                          stall,
    output logic [WIDTH-1:0]              mask,
    output logic                          gie,
    output logic [depth_width(WIDTH)-1:0] depth,
    output logic                          spurious_reti
);

    localparam int               DW          = depth_width(WIDTH);
    localparam logic [DW-1:0]    C_DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0]    C_DEPTH_MAX = DW'(WIDTH);
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   r_sel;
    logic [WIDTH-1:0]   r_la;
    logic [WIDTH-1:0]   r_mask;
    logic               r_gie;
    logic [DW-1:0]      r_depth;
    logic               r_spurious;

    logic [WIDTH-1:0]   w_la;
    logic [WIDTH-1:0]   w_prio_ok;
    logic [WIDTH-1:0]   w_elig;
    logic [WIDTH-1:0]   w_sel;
    logic               w_do_pop;
    logic               w_do_take;

    // Lowest attended line: the interrupt currently being serviced.
    max_priority_bit #(
        .WIDTH (WIDTH)
    ) u_la_pick (
        .req   (int_a),
        .grant (w_la)
    );

    // la - 1 sets every bit strictly below the attended line, i.e. exactly
    // the lines allowed to preempt it.
    assign w_prio_ok = (int_a == '0) ? '1 : (w_la - C_ONE);
    assign w_elig    = int_s & r_mask & ~int_a & w_prio_ok;

    max_priority_bit #(
        .WIDTH (WIDTH)
    ) u_sel_pick (
        .req   (w_elig),
        .grant (w_sel)
    );

    // A reti in IDLE always wins over taking a new interrupt.
    assign w_do_pop  = reti_inst && (r_depth != '0);
    assign w_do_take = !reti_inst && r_gie && instr_boundary && (w_elig != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_do_pop) begin
                    w_state_nxt = POP;
                end else if (w_do_take) begin
                    w_state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (push_ack) begin
                    w_state_nxt = VECTOR;
                end
            end
            VECTOR:  w_state_nxt = IDLE;
            POP: begin
                if (pop_ack) begin
                    w_state_nxt = RETI;
                end
            end
            RETI:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_la       <= '0;
            r_mask     <= '0;
            r_gie      <= 1'b0;
            r_depth    <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == IDLE) begin
                if (w_do_pop) begin
                    r_la <= w_la;
                end else if (w_do_take) begin
                    r_sel <= w_sel;
                end
                if (reti_inst && (r_depth == '0)) begin
                    r_spurious <= 1'b1;
                end
            end

            // Depth moves as the VECTOR / RETI cycle completes, so the next
            // IDLE cycle sees the same nesting level the manager reports.
            if (r_state == VECTOR) begin
                r_depth <= r_depth + C_DEPTH_ONE;
            end else if (r_state == RETI) begin
                r_depth <= r_depth - C_DEPTH_ONE;
            end

            if (mask_we) begin
                r_mask <= mask_d;
            end

            if (gie_clr) begin
                r_gie <= 1'b0;
            end else if (gie_set) begin
                r_gie <= 1'b1;
            end
        end
    end

    // Every output is a decode of registered state, so no ack reaches the
    // update pulses combinationally and reset clears them immediately.
    assign pc_push       = (r_state == PUSH);
    assign pc_pop        = (r_state == POP);
    assign irq_take      = (r_state == VECTOR);
    assign s_calli       = (r_state == VECTOR) ? r_sel : '0;
    assign s_reti        = (r_state == RETI)   ? r_la  : '0;
    assign stall         = (r_state != IDLE);
    assign mask          = r_mask;
    assign gie           = r_gie;
    assign depth         = r_depth;
    assign spurious_reti = r_spurious;

    // Strict preemption means the counter can never exceed WIDTH.
    a_depth_bound : assert property (
        @(posedge clk) disable iff (reset)
        (r_state == VECTOR) |-> (r_depth < C_DEPTH_MAX)
    );

endmodule
`default_nettype wire

// File: tb/tb_int_dispatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_int_dispatch_ctrl
// Description : Self-checking bench for int_dispatch_ctrl. A transaction-
//               level model expands each take / retire decision into the
//               expected per-cycle output sequence and also plays the role
//               of interrupt_manager (Request / Attention registers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_dispatch_ctrl;

    localparam int W  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  int_s, int_a, mask_d;
    logic          instr_boundary, reti_inst, mask_we, gie_set, gie_clr;
    logic          push_ack, pop_ack;
    logic [W-1:0]  s_calli, s_reti, mask;
    logic          irq_take, pc_push, pc_pop, stall, gie, spurious_reti;
    logic [DW-1:0] depth;

    int_dispatch_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .int_s          (int_s),
        .int_a          (int_a),
        .instr_boundary (instr_boundary),
        .reti_inst      (reti_inst),
        .mask_we        (mask_we),
        .mask_d         (mask_d),
        .gie_set        (gie_set),
        .gie_clr        (gie_clr),
        .push_ack       (push_ack),
        .pop_ack        (pop_ack),
        .s_calli        (s_calli),
        .s_reti         (s_reti),
        .irq_take       (irq_take),
        .pc_push        (pc_push),
        .pc_pop         (pc_pop),
        .stall          (stall),
        .mask           (mask),
        .gie            (gie),
        .depth          (depth),
        .spurious_reti  (spurious_reti)
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle of a take / retire transaction.
    typedef struct packed {
        logic         stall;
        logic         push;
        logic         pop;
        logic         take;
        logic         ack;
        logic [W-1:0] calli;
        logic [W-1:0] reti;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state (interrupt manager + controller configuration).
    logic [W-1:0] m_int_s, m_int_a, m_mask, pend_set_a, pend_clr_a;
    logic         m_gie, m_spur;
    int           m_depth;

    // One-shot configuration writes consumed by the next step.
    logic         d_mask_we, d_gset, d_gclr;
    logic [W-1:0] d_mask_d;

    int stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lowest(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[i]) return W'(1) << i;
        end
        return '0;
    endfunction

    function automatic exp_t mk(input logic st, input logic pu, input logic po,
                                input logic tk, input logic ak,
                                input logic [W-1:0] c, input logic [W-1:0] r);
        exp_t e;
        e.stall = st; e.push = pu; e.pop = po; e.take = tk; e.ack = ak;
        e.calli = c;  e.reti = r;
        return e;
    endfunction

    // One clock cycle: apply manager updates, check this cycle's outputs,
    // drive inputs sampled at the next edge, and extend the expectation.
    task automatic step(input logic [W-1:0] req_set, input logic [W-1:0] req_clr,
                        input logic reti_in, input logic bnd, input int dly);
        exp_t         cur;
        logic         idle;
        logic [W-1:0] la, prio, elig;
        @(negedge clk);
        m_int_a    = (m_int_a | pend_set_a) & ~pend_clr_a;
        m_int_s    = ((m_int_s & ~pend_set_a) | req_set) & ~req_clr;
        pend_set_a = '0;
        pend_clr_a = '0;
        int_a      = m_int_a;
        int_s      = m_int_s;

        idle = (q.size() == 0);
        if (idle) cur = '0;
        else      cur = q.pop_front();

        check("stall",    32'(stall),         32'(cur.stall));
        check("pc_push",  32'(pc_push),       32'(cur.push));
        check("pc_pop",   32'(pc_pop),        32'(cur.pop));
        check("irq_take", 32'(irq_take),      32'(cur.take));
        check("s_calli",  32'(s_calli),       32'(cur.calli));
        check("s_reti",   32'(s_reti),        32'(cur.reti));
        check("mask",     32'(mask),          32'(m_mask));
        check("gie",      32'(gie),           32'(m_gie));
        check("depth",    32'(depth),         32'(m_depth));
        check("spurious", 32'(spurious_reti), 32'(m_spur));

        push_ack       = cur.push & cur.ack;
        pop_ack        = cur.pop & cur.ack;
        reti_inst      = reti_in;
        instr_boundary = bnd;
        mask_we        = d_mask_we;
        mask_d         = d_mask_d;
        gie_set        = d_gset;
        gie_clr        = d_gclr;

        if (idle) begin
            la   = lowest(m_int_a);
            prio = (m_int_a == '0) ? '1 : la - W'(1);
            elig = m_int_s & m_mask & ~m_int_a & prio;
            if (reti_in && m_depth > 0) begin
                for (int k = 0; k <= dly; k++) q.push_back(mk(1, 0, 1, 0, k == dly, '0, '0));
                q.push_back(mk(1, 0, 0, 0, 0, '0, la));
            end else if (reti_in) begin
                m_spur = 1'b1;
            end else if (m_gie && bnd && elig != '0) begin
                for (int k = 0; k <= dly; k++) q.push_back(mk(1, 1, 0, 0, k == dly, '0, '0));
                q.push_back(mk(1, 0, 0, 1, 0, lowest(elig), '0));
            end
        end

        if (cur.take)       m_depth++;
        if (cur.reti != '0) m_depth--;
        pend_set_a = cur.calli;
        pend_clr_a = cur.reti;
        if (d_mask_we) m_mask = d_mask_d;
        if (d_gclr)      m_gie = 1'b0;
        else if (d_gset) m_gie = 1'b1;
        d_mask_we = 1'b0;
        d_gset    = 1'b0;
        d_gclr    = 1'b0;
    endtask

    task automatic model_clear();
        q.delete();
        m_int_s = '0; m_int_a = '0; m_mask = '0;
        pend_set_a = '0; pend_clr_a = '0;
        m_gie = 1'b0; m_spur = 1'b0; m_depth = 0;
        d_mask_we = 1'b0; d_gset = 1'b0; d_gclr = 1'b0; d_mask_d = '0;
    endtask

    initial begin
        reset = 1'b1;
        int_s = '0; int_a = '0; mask_d = '0;
        instr_boundary = 1'b0; reti_inst = 1'b0; mask_we = 1'b0;
        gie_set = 1'b0; gie_clr = 1'b0; push_ack = 1'b0; pop_ack = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall",  32'(stall),         0);
        check("rst_mask",   32'(mask),          0);
        check("rst_gie",    32'(gie),           0);
        check("rst_depth",  32'(depth),         0);
        check("rst_calli",  32'(s_calli),       0);
        check("rst_spur",   32'(spurious_reti), 0);
        reset = 1'b0;

        // Basic take of line 2 with immediate ack
        d_mask_we = 1'b1; d_mask_d = 8'hFF; d_gset = 1'b1;
        step('0, '0, 0, 0, 0);
        step(8'h04, '0, 0, 1, 0);
        step('0, '0, 0, 0, 0);
        check("t1_push", 32'(pc_push), 1);
        step('0, '0, 0, 0, 0);
        check("t1_calli", 32'(s_calli), 32'h04);
        check("t1_take",  32'(irq_take), 1);
        step('0, '0, 0, 0, 0);
        check("t1_depth", 32'(depth), 1);

        // Nesting: 02 preempts 04, 08 must wait
        step(8'h0A, '0, 0, 1, 0);
        step('0, '0, 0, 1, 0);
        step('0, '0, 0, 1, 0);
        check("t2_calli", 32'(s_calli), 32'h02);
        step('0, '0, 0, 1, 0);
        check("t2_depth", 32'(depth), 2);
        check("t2_hold",  32'(stall), 0);

        // Two retis unwind 02 then 04, then a spurious reti
        step('0, '0, 1, 0, 0);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        check("t3_reti1", 32'(s_reti), 32'h02);
        step('0, '0, 1, 0, 1);
        check("t3_depth1", 32'(depth), 1);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        check("t3_reti2", 32'(s_reti), 32'h04);
        step('0, '0, 1, 0, 0);
        check("t3_depth0", 32'(depth), 0);
        step('0, '0, 0, 0, 0);
        check("t3_spur",  32'(spurious_reti), 1);
        check("t3_noret", 32'(s_reti), 0);

        // Deferred 08 is now taken
        step('0, '0, 0, 1, 1);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        check("t4_calli", 32'(s_calli), 32'h08);

        // reti and eligible request together: pop first, take after
        step(8'h02, '0, 1, 1, 0);
        step('0, '0, 0, 1, 0);
        check("t5_pop", 32'(pc_pop), 1);
        step('0, '0, 0, 1, 0);
        check("t5_reti", 32'(s_reti), 32'h08);
        step('0, '0, 0, 1, 0);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        check("t5_calli", 32'(s_calli), 32'h02);
        step('0, '0, 1, 0, 0);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);
        step('0, '0, 0, 0, 0);

        // Delayed push_ack while the request drops
        step(8'h01, '0, 0, 1, 3);
        stall_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step('0, 8'h01, 0, 0, 0);
            stall_cnt += 32'(stall);
            if (k == 4) check("t6_calli", 32'(s_calli), 32'h01);
        end
        check("t6_stall_cycles", stall_cnt, 5);
        step('0, '0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step('0, '0, 0, 0, 0);

        // Reset asserted in the middle of PUSH
        step(8'h10, '0, 0, 1, 3);
        step('0, '0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        check("t7_push",  32'(pc_push), 0);
        check("t7_stall", 32'(stall), 0);
        check("t7_depth", 32'(depth), 0);
        check("t7_mask",  32'(mask), 0);
        check("t7_gie",   32'(gie), 0);
        model_clear();
        int_s = '0; int_a = '0; push_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step(8'h10, '0, 0, 1, 0);

        // Randomized traffic
        d_mask_we = 1'b1; d_mask_d = 8'hFF; d_gset = 1'b1;
        step('0, '0, 0, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            logic [W-1:0] rs, rc;
            rs = ($urandom_range(0, 3) == 0) ? W'(1) << $urandom_range(0, W - 1) : '0;
            rc = ($urandom_range(0, 9) == 0) ? W'(1) << $urandom_range(0, W - 1) : '0;
            if ($urandom_range(0, 9) == 0) begin
                d_mask_we = 1'($urandom_range(0, 1));
                d_mask_d  = W'($urandom | $urandom);
                d_gset    = ($urandom_range(0, 3) != 0);
                d_gclr    = ($urandom_range(0, 3) == 0);
            end
            step(rs, rc, $urandom_range(0, 6) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
